// File: rtl/part_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : part_ctrl_pkg
// Description : Shared op codes, FSM state encoding and field widths for the
//               part_tester pin sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package part_ctrl_pkg;

    localparam int c_len_w = 16;
    localparam int c_run_w = 16;

    localparam logic [2:0] c_op_reset    = 3'd0;
    localparam logic [2:0] c_op_scan_in  = 3'd1;
    localparam logic [2:0] c_op_scan_out = 3'd2;
    localparam logic [2:0] c_op_exec     = 3'd3;
    localparam logic [2:0] c_op_free_run = 3'd4;

    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_IDLE    = 4'd1,
        ST_SI_WAIT = 4'd2,
        ST_SI_LO   = 4'd3,
        ST_SI_HI   = 4'd4,
        ST_SO_LO   = 4'd5,
        ST_SO_WAIT = 4'd6,
        ST_SO_HI   = 4'd7,
        ST_RUN_LO  = 4'd8,
        ST_RUN_HI  = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/part_clk_phase.sv
`default_nettype none
// ============================================================================
// Module      : part_clk_phase
// Description : DIV-clock phase timer; start restarts it, phase_done marks the
//               last clock of the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module part_clk_phase #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic phase_done
);

    localparam logic [7:0] c_last = 8'(DIV - 1);

    logic [7:0] r_cnt;

    assign phase_done = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (start) begin
            r_cnt <= 8'd0;
        end else if (!phase_done) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/part_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : part_seq_ctrl
// Description : Drives the part-under-test clock, reset, scan-enable and scan
//               data pins from decoded host commands.
// Revision    : 1.0 - initial release
// ============================================================================
module part_seq_ctrl
    import part_ctrl_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd_op,
    input  logic [c_len_w-1:0]  cmd_len,
    output logic                cmd_ready,
    output logic                cmd_err,
    input  logic                pause,
    input  logic                bit_in,
    input  logic                bit_in_valid,
    output logic                bit_in_ready,
    output logic                bit_out,
    output logic                bit_out_valid,
    input  logic                bit_out_ready,
    output logic                part_clk,
    output logic                part_rstn,
    output logic                part_se,
    output logic                part_tm,
    output logic                part_si,
    input  logic                part_so,
    output logic                busy,
    output logic [c_run_w-1:0]  run_count
);

    localparam logic [c_len_w-1:0] c_rst_last = c_len_w'(RST_CYCLES - 1);
    localparam logic [c_len_w-1:0] c_rst_done = c_len_w'(RST_CYCLES);

    state_t               r_state, w_state_n;
    logic [c_len_w-1:0]   r_len, r_cnt, w_cnt_p1;
    logic [c_run_w-1:0]   r_run_count;
    logic                 r_free, r_scan_mode, r_part_clk, r_part_rstn;
    logic                 r_part_si, r_bit_out, r_cmd_err;
    logic                 w_accept, w_start, w_phase_done, w_len_hit;
    logic                 w_cnt_inc, w_run_inc, w_capture, w_si_take;

    part_clk_phase #(.DIV(DIV)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .phase_done (w_phase_done)
    );

    assign w_cnt_p1  = r_cnt + c_len_w'(1);
    assign w_len_hit = (r_cnt == r_len);
    assign w_accept  = cmd_valid && (r_state == ST_IDLE);

    assign cmd_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign bit_in_ready  = (r_state == ST_SI_WAIT) && !w_len_hit;
    assign bit_out_valid = (r_state == ST_SO_WAIT);
    assign bit_out       = r_bit_out;
    assign cmd_err       = r_cmd_err;
    assign part_clk      = r_part_clk;
    assign part_rstn     = r_part_rstn;
    assign part_se       = r_scan_mode;
    assign part_tm       = r_scan_mode;
    assign part_si       = r_part_si;
    assign run_count     = r_run_count;

    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_cnt_inc = 1'b0;
        w_run_inc = 1'b0;
        w_capture = 1'b0;
        w_si_take = 1'b0;
        case (r_state)
            ST_RST: if (r_cnt == c_rst_done) w_state_n = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        c_op_reset:    w_state_n = ST_RST;
                        c_op_scan_in:  w_state_n = ST_SI_WAIT;
                        c_op_scan_out: begin w_state_n = ST_SO_LO;  w_start = 1'b1; end
                        c_op_exec,
                        c_op_free_run: begin w_state_n = ST_RUN_LO; w_start = 1'b1; end
                        default:       w_state_n = ST_IDLE;
                    endcase
                end
            end
            // The length checks in the WAIT/LO states only fire for len = 0.
            ST_SI_WAIT: begin
                if (w_len_hit) begin
                    w_state_n = ST_IDLE;
                end else if (bit_in_valid) begin
                    w_si_take = 1'b1;
                    w_state_n = ST_SI_LO;
                    w_start   = 1'b1;
                end
            end
            ST_SI_LO: if (w_phase_done) begin w_state_n = ST_SI_HI; w_start = 1'b1; end
            ST_SI_HI: begin
                if (w_phase_done) begin
                    w_cnt_inc = 1'b1;
                    w_state_n = (w_cnt_p1 == r_len) ? ST_IDLE : ST_SI_WAIT;
                end
            end
            ST_SO_LO: begin
                if (w_len_hit) begin
                    w_state_n = ST_IDLE;
                end else if (w_phase_done) begin
                    w_capture = 1'b1;
                    w_state_n = ST_SO_WAIT;
                end
            end
            ST_SO_WAIT: if (bit_out_ready) begin w_state_n = ST_SO_HI; w_start = 1'b1; end
            ST_SO_HI: begin
                if (w_phase_done) begin
                    w_cnt_inc = 1'b1;
                    w_state_n = (w_cnt_p1 == r_len) ? ST_IDLE : ST_SO_LO;
                    w_start   = (w_cnt_p1 != r_len);
                end
            end
            ST_RUN_LO: begin
                if (!r_free && w_len_hit) begin
                    w_state_n = ST_IDLE;
                end else if (w_phase_done) begin
                    w_state_n = ST_RUN_HI;
                    w_start   = 1'b1;
                end
            end
            ST_RUN_HI: begin
                if (w_phase_done) begin
                    w_cnt_inc = 1'b1;
                    w_run_inc = 1'b1;
                    if (r_free ? pause : (w_cnt_p1 == r_len)) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_RUN_LO;
                        w_start   = 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RST;
            r_len       <= '0;
            r_cnt       <= '0;
            r_run_count <= '0;
            r_free      <= 1'b0;
            r_scan_mode <= 1'b0;
            r_part_clk  <= 1'b0;
            r_part_rstn <= 1'b0;
            r_part_si   <= 1'b0;
            r_bit_out   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_part_clk <= (w_state_n == ST_SI_HI) || (w_state_n == ST_SO_HI) ||
                          (w_state_n == ST_RUN_HI);
            r_cmd_err  <= w_accept && (cmd_op > c_op_free_run);

            if (w_accept) begin
                r_len  <= cmd_len;
                r_cnt  <= '0;
                r_free <= (cmd_op == c_op_free_run);
            end else if ((r_state == ST_RST) || w_cnt_inc) begin
                r_cnt <= w_cnt_p1;
            end

            if (w_accept && (cmd_op == c_op_reset)) begin
                r_part_rstn <= 1'b0;
            end else if ((r_state == ST_RST) && (r_cnt == c_rst_last)) begin
                r_part_rstn <= 1'b1;
            end

            // Mode pins only move for commands that will actually clock the part.
            if (w_accept) begin
                case (cmd_op)
                    c_op_scan_in,
                    c_op_scan_out: if (cmd_len != '0) r_scan_mode <= 1'b1;
                    c_op_exec:     if (cmd_len != '0) r_scan_mode <= 1'b0;
                    c_op_reset,
                    c_op_free_run: r_scan_mode <= 1'b0;
                    default:       ;
                endcase
            end

            if (w_si_take) begin
                r_part_si <= bit_in;
            end else if (w_capture) begin
                r_part_si <= part_so;
            end
            if (w_capture) r_bit_out <= part_so;

            if (w_accept && ((cmd_op == c_op_exec) || (cmd_op == c_op_free_run))) begin
                r_run_count <= '0;
            end else if (w_run_inc && (r_run_count != '1)) begin
                r_run_count <= r_run_count + c_run_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_part_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_part_seq_ctrl
// Description : Directed bench for part_seq_ctrl with an 8-bit scan chain model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_part_seq_ctrl;

    localparam int DIV        = 2;
    localparam int RST_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        pause = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_in_valid = 1'b0;
    logic        bit_out_ready = 1'b0;
    logic        cmd_ready, cmd_err, bit_in_ready, bit_out, bit_out_valid;
    logic        part_clk, part_rstn, part_se, part_tm, part_si, part_so, busy;
    logic [15:0] run_count;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          se_hi = 0;
    int          tm_hi = 0;
    logic [7:0]  si_log = 8'd0;
    logic [7:0]  chain = 8'd0;
    logic [7:0]  load_val = 8'd0;
    logic        load_req = 1'b0;

    part_seq_ctrl #(.DIV(DIV), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err), .pause(pause),
        .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_in_ready(bit_in_ready),
        .bit_out(bit_out), .bit_out_valid(bit_out_valid), .bit_out_ready(bit_out_ready),
        .part_clk(part_clk), .part_rstn(part_rstn), .part_se(part_se),
        .part_tm(part_tm), .part_si(part_si), .part_so(part_so),
        .busy(busy), .run_count(run_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Part model: 8-bit scan chain shifting toward bit 0 on each part_clk rise.
    assign part_so = chain[0];
    always @(posedge part_clk or posedge load_req) begin
        if (load_req) begin
            chain = load_val;
        end else begin
            pulses++;
            se_hi += int'(part_se);
            tm_hi += int'(part_tm);
            si_log = {part_si, si_log[7:1]};
            chain  = {part_si, chain[7:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int limit, output int n);
        n = 0;
        while (!cmd_ready && n < limit) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int         n, lows, t0, p0, s0, m0;
        logic [7:0] si_bits, got;
        logic       ok;

        // Reset state
        repeat (3) tick();
        chk("rst_pins", {22'd0, part_clk, part_rstn, part_se, part_tm, part_si,
                         bit_out, bit_out_valid, cmd_err, cmd_ready, busy}, 32'h001);
        chk("rst_run_count", {16'd0, run_count}, 32'd0);

        // Automatic RST sequence after release
        rst = 1'b0; lows = 0; n = 0;
        while (!cmd_ready && n < 100) begin
            if (!part_rstn) lows++;
            tick();
            n++;
        end
        chk("rst_ready_delay", n, 32'd17);
        chk("rst_rstn_low", lows, 32'd16);
        chk("rst_rstn_high", {31'd0, part_rstn}, 32'd1);
        chk("rst_no_pclk", pulses, 32'd0);

        // SCAN_IN len=8, bits 1,0,0,0,1,1,1,1 (first bit lands in si_log[0])
        si_bits = 8'hF1; p0 = pulses; s0 = se_hi; m0 = tm_hi;
        send_cmd(3'd1, 16'd8);
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bit_in = si_bits[i];
            bit_in_valid = 1'b1;
            n = 0;
            while (!bit_in_ready && n < 50) begin
                tick();
                n++;
            end
            chk("si_ready", {31'd0, bit_in_ready}, 32'd1);
            tick();
            bit_in_valid = 1'b0;
        end
        wait_ready("si_done", 100, n);
        chk("si_cycles", cyc - t0, 32'd40);
        chk("si_pulses", pulses - p0, 32'd8);
        chk("si_bits", {24'd0, si_log}, 32'hF1);
        chk("si_se", se_hi - s0, 32'd8);
        chk("si_tm", tm_hi - m0, 32'd8);

        // EXEC len=0
        p0 = pulses;
        send_cmd(3'd3, 16'd0);
        tick();
        chk("exec0_idle", {31'd0, cmd_ready}, 32'd1);
        chk("exec0_pulses", pulses - p0, 32'd0);
        chk("exec0_run_count", {16'd0, run_count}, 32'd0);

        // EXEC len=10 with pause held high (pause ignored outside FREE_RUN)
        p0 = pulses; s0 = se_hi; m0 = tm_hi; pause = 1'b1;
        send_cmd(3'd3, 16'd10);
        wait_ready("exec_done", 200, n);
        pause = 1'b0;
        chk("exec_pulses", pulses - p0, 32'd10);
        chk("exec_run_count", {16'd0, run_count}, 32'd10);
        chk("exec_se", se_hi - s0, 32'd0);
        chk("exec_tm", tm_hi - m0, 32'd0);
        chk("exec_pclk_low", {31'd0, part_clk}, 32'd0);

        // SCAN_OUT len=8 against chain preloaded 0xA9, stall on bit 3
        load_val = 8'hA9; load_req = 1'b1; #1; load_req = 1'b0;
        p0 = pulses; got = 8'd0; ok = 1'b1; bit_out_ready = 1'b1;
        send_cmd(3'd2, 16'd8);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!bit_out_valid && n < 50) begin
                tick();
                n++;
            end
            chk("so_valid", {31'd0, bit_out_valid}, 32'd1);
            got[i] = bit_out;
            if (i == 3) begin
                bit_out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    if (part_clk !== 1'b0 || bit_out_valid !== 1'b1) ok = 1'b0;
                end
                bit_out_ready = 1'b1;
            end
            tick();
        end
        wait_ready("so_done", 100, n);
        chk("so_bits", {24'd0, got}, 32'hA9);
        chk("so_chain_intact", {24'd0, chain}, 32'hA9);
        chk("so_pulses", pulses - p0, 32'd8);
        chk("so_stall_clk_low", {31'd0, ok}, 32'd1);
        chk("so_run_count_kept", {16'd0, run_count}, 32'd10);

        // FREE_RUN, pause raised in the first clock of cycle 12's high phase
        p0 = pulses;
        send_cmd(3'd4, 16'd0);
        n = 0;
        while ((pulses - p0) < 12 && n < 200) begin
            tick();
            n++;
        end
        chk("fr_reach12", pulses - p0, 32'd12);
        pause = 1'b1;
        wait_ready("fr_stop", 50, n);
        pause = 1'b0;
        chk("fr_pulses", pulses - p0, 32'd12);
        chk("fr_run_count", {16'd0, run_count}, 32'd12);
        chk("fr_pclk_low", {31'd0, part_clk}, 32'd0);

        // Illegal op
        send_cmd(3'd6, 16'd0);
        chk("err_pulse", {31'd0, cmd_err}, 32'd1);
        chk("err_idle", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("err_clear", {31'd0, cmd_err}, 32'd0);

        // rst in the middle of SCAN_OUT
        send_cmd(3'd2, 16'd8);
        repeat (6) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_pins", {22'd0, part_clk, part_rstn, part_se, part_tm, part_si,
                             bit_out, bit_out_valid, cmd_err, cmd_ready, busy}, 32'h001);
        chk("mid_rst_run_count", {16'd0, run_count}, 32'd0);
        rst = 1'b0;
        wait_ready("mid_rerun", 100, n);
        chk("mid_rerun_delay", n, 32'd17);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
